// File: rtl/u409_pkg.sv
// Shared types and helpers for the U409 buffer sequencer and the address decode.
// Direction encoding, dwell-counter width and the one-hot check live here.
package u409_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETDIR = 2'd1,
        ACTIVE = 2'd2,
        TURN   = 2'd3
    } state_e;

    localparam logic DIR_TO_CPU = 1'b1;
    localparam logic DIR_TO_BUS = 1'b0;

    localparam int unsigned DWELL_W = 4;
    localparam int unsigned MAX_CH  = 8;

    // True when exactly one bit is set; narrower selects are zero-extended by the caller.
    function automatic logic is_onehot(input logic [MAX_CH-1:0] v);
        return (v != '0) && ((v & (v - MAX_CH'(1))) == '0);
    endfunction

endpackage

// File: rtl/u409_buffer_sequencer_if.sv
// Local-bus buffer-control bundle between address decode, the sequencer and the
// transfer-acknowledge logic.
interface u409_buffer_sequencer_if #(
    parameter int unsigned N_CH = 2
);
    logic            ACCESS;
    logic [N_CH-1:0] SEL;
    logic            RW;
    logic            DMA;
    logic [N_CH-1:0] BUFENn;
    logic [N_CH-1:0] BUFDIR;
    logic            BUF_RDY;
    logic            SEL_ERR;

    modport master (
        output ACCESS, SEL, RW, DMA,
        input  BUFENn, BUFDIR, BUF_RDY, SEL_ERR
    );

    modport slave (
        input  ACCESS, SEL, RW, DMA,
        output BUFENn, BUFDIR, BUF_RDY, SEL_ERR
    );
endinterface

// File: rtl/u409_dwell_counter.sv
// Loadable down-counter shared by the direction-setup and turnaround dwells.
// Saturates at zero; last_o flags the cycle whose decrement reaches zero.
module u409_dwell_counter
    import u409_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic [DWELL_W-1:0] load_val_i,
    input  logic               dec_i,
    output logic               zero_o,
    output logic               last_o
);

    logic [DWELL_W-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && !zero_o) begin
            count_q <= count_q - DWELL_W'(1);
        end
    end

    assign zero_o = (count_q == '0);
    assign last_o = (count_q == DWELL_W'(1));

endmodule

// File: rtl/u409_buffer_sequencer.sv
// Sequences direction then enable for each buffer group, with a turnaround dwell after
// release so no two groups ever drive the local bus together. All outputs registered.
module u409_buffer_sequencer
    import u409_pkg::*;
#(
    parameter int unsigned N_CH      = 2,
    parameter int unsigned DIR_SETUP = 1,
    parameter int unsigned TURN_CYC  = 1
) (
    input  logic                    CLK40,
    input  logic                    RESET,
    u409_buffer_sequencer_if.slave  bus
);

    localparam logic [DWELL_W-1:0] SETUP_LD = DWELL_W'(DIR_SETUP);
    localparam logic [DWELL_W-1:0] TURN_LD  = DWELL_W'(TURN_CYC);

    state_e             state_q, state_d;
    logic [N_CH-1:0]    sel_q, sel_d;
    logic [N_CH-1:0]    en_d;
    logic [N_CH-1:0]    bufen_q, bufdir_q;
    logic               rdy_q, rdy_d;
    logic               err_q, err_d;
    logic               dir_load;
    logic               dir_val;
    logic               sel_one, sel_none;
    logic               cnt_load, cnt_dec, cnt_zero, cnt_last;
    logic [DWELL_W-1:0] cnt_val;

    assign sel_one  = is_onehot(MAX_CH'(bus.SEL));
    assign sel_none = (bus.SEL == '0);

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        en_d     = '0;
        rdy_d    = 1'b0;
        err_d    = 1'b0;
        dir_load = 1'b0;
        dir_val  = (bus.RW ^ bus.DMA) ? DIR_TO_CPU : DIR_TO_BUS;
        cnt_load = 1'b0;
        cnt_val  = SETUP_LD;
        cnt_dec  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.ACCESS) begin
                    if (sel_one) begin
                        sel_d    = bus.SEL;
                        dir_load = 1'b1;
                        if (DIR_SETUP == 0) begin
                            state_d = ACTIVE;
                            en_d    = bus.SEL;
                            rdy_d   = 1'b1;
                        end else begin
                            state_d  = SETDIR;
                            cnt_load = 1'b1;
                        end
                    end else if (sel_none) begin
                        rdy_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SETDIR, ACTIVE: begin
                cnt_dec = (state_q == SETDIR);
                if (!bus.ACCESS) begin
                    // Dropping the access still pays the turnaround dwell.
                    if (TURN_CYC == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d  = TURN;
                        cnt_load = 1'b1;
                        cnt_val  = TURN_LD;
                    end
                end else if (state_q == ACTIVE || cnt_last || cnt_zero) begin
                    state_d = ACTIVE;
                    en_d    = sel_q;
                    rdy_d   = 1'b1;
                end
            end
            TURN: begin
                cnt_dec = 1'b1;
                if (cnt_last || cnt_zero) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK40) begin
        if (RESET) begin
            state_q <= IDLE;
            sel_q   <= '0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
        end
    end

    u409_dwell_counter u_dwell (
        .clk_i      (CLK40),
        .rst_i      (RESET),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero),
        .last_o     (cnt_last)
    );

    for (genvar g = 0; g < N_CH; g++) begin : g_grp
        logic en_n_q;
        logic dir_q;

        always_ff @(posedge CLK40) begin
            if (RESET) begin
                en_n_q <= 1'b1;
                dir_q  <= 1'b0;
            end else begin
                en_n_q <= ~en_d[g];
                if (dir_load && bus.SEL[g]) begin
                    dir_q <= dir_val;
                end
            end
        end

        assign bufen_q[g]  = en_n_q;
        assign bufdir_q[g] = dir_q;
    end

    assign bus.BUFENn  = bufen_q;
    assign bus.BUFDIR  = bufdir_q;
    assign bus.BUF_RDY = rdy_q;
    assign bus.SEL_ERR = err_q;

endmodule

// File: tb/tb_u409_buffer_sequencer.sv
// Cycle-by-cycle scoreboard bench for u409_buffer_sequencer: default-parameter instance
// plus a DIR_SETUP = 0 / TURN_CYC = 0 instance. Vectors are {BUFENn, BUFDIR, BUF_RDY, SEL_ERR}.
module tb_u409_buffer_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;
    logic [5:0] sb [$];

    always #5 clk = ~clk;

    u409_buffer_sequencer_if #(.N_CH(2)) bus_a ();
    u409_buffer_sequencer_if #(.N_CH(2)) bus_b ();

    u409_buffer_sequencer #(.N_CH(2), .DIR_SETUP(1), .TURN_CYC(1)) dut (
        .CLK40 (clk),
        .RESET (rst),
        .bus   (bus_a)
    );

    u409_buffer_sequencer #(.N_CH(2), .DIR_SETUP(0), .TURN_CYC(0)) dut0 (
        .CLK40 (clk),
        .RESET (rst),
        .bus   (bus_b)
    );

    // Stimulus words are {RESET, ACCESS, SEL[1:0], RW, DMA}.

    task automatic test_reset();
        logic [5:0] st [0:2] = '{6'b100000, 6'b100000, 6'b000000};
        logic [5:0] ex [0:2] = '{6'b110000, 6'b110000, 6'b110000};
        logic [5:0] obs, e;
        for (int i = 0; i < 3; i++) begin
            {rst, bus_a.ACCESS, bus_a.SEL, bus_a.RW, bus_a.DMA} = st[i];
            sb.push_back(ex[i]);
            @(posedge clk); #1;
            e   = sb.pop_front();
            obs = {bus_a.BUFENn, bus_a.BUFDIR, bus_a.BUF_RDY, bus_a.SEL_ERR};
            total++;
            if (obs !== e) $display("FAIL reset[%0d] got %b want %b", i, obs, e);
            else passed++;
        end
        // The zero-dwell instance must come out of reset the same way.
        total++;
        obs = {bus_b.BUFENn, bus_b.BUFDIR, bus_b.BUF_RDY, bus_b.SEL_ERR};
        if (obs !== 6'b110000) $display("FAIL reset_dut0 got %b want 110000", obs);
        else passed++;
    endtask

    task automatic test_read();
        logic [5:0] st [0:6] = '{6'b010110, 6'b010110, 6'b010110, 6'b010110,
                                 6'b000000, 6'b000000, 6'b000000};
        logic [5:0] ex [0:6] = '{6'b110100, 6'b100110, 6'b100110, 6'b100110,
                                 6'b110100, 6'b110100, 6'b110100};
        logic [5:0] obs, e;
        for (int i = 0; i < 7; i++) begin
            {rst, bus_a.ACCESS, bus_a.SEL, bus_a.RW, bus_a.DMA} = st[i];
            sb.push_back(ex[i]);
            @(posedge clk); #1;
            e   = sb.pop_front();
            obs = {bus_a.BUFENn, bus_a.BUFDIR, bus_a.BUF_RDY, bus_a.SEL_ERR};
            total++;
            if (obs !== e) $display("FAIL read[%0d] got %b want %b", i, obs, e);
            else passed++;
        end
    endtask

    // DMA inverts direction; RW/SEL changes while ACTIVE must be ignored.
    task automatic test_dma();
        logic [5:0] st [0:9] = '{6'b011001, 6'b011001, 6'b010111, 6'b000000, 6'b000000,
                                 6'b011011, 6'b011011, 6'b000000, 6'b000000, 6'b000000};
        logic [5:0] ex [0:9] = '{6'b111100, 6'b011110, 6'b011110, 6'b111100, 6'b111100,
                                 6'b110100, 6'b010110, 6'b110100, 6'b110100, 6'b110100};
        logic [5:0] obs, e;
        for (int i = 0; i < 10; i++) begin
            {rst, bus_a.ACCESS, bus_a.SEL, bus_a.RW, bus_a.DMA} = st[i];
            sb.push_back(ex[i]);
            @(posedge clk); #1;
            e   = sb.pop_front();
            obs = {bus_a.BUFENn, bus_a.BUFDIR, bus_a.BUF_RDY, bus_a.SEL_ERR};
            total++;
            if (obs !== e) $display("FAIL dma[%0d] got %b want %b", i, obs, e);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] st [0:11] = '{6'b010100, 6'b010100, 6'b010100, 6'b000000,
                                  6'b011010, 6'b011010, 6'b011010, 6'b011010,
                                  6'b011010, 6'b000000, 6'b000000, 6'b000000};
        logic [5:0] ex [0:11] = '{6'b110000, 6'b100010, 6'b100010, 6'b110000,
                                  6'b110000, 6'b111000, 6'b011010, 6'b011010,
                                  6'b011010, 6'b111000, 6'b111000, 6'b111000};
        logic [5:0] obs, e;
        int gap = 0, both_on = 0;
        logic seen_en = 1'b0, done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            {rst, bus_a.ACCESS, bus_a.SEL, bus_a.RW, bus_a.DMA} = st[i];
            sb.push_back(ex[i]);
            @(posedge clk); #1;
            e   = sb.pop_front();
            obs = {bus_a.BUFENn, bus_a.BUFDIR, bus_a.BUF_RDY, bus_a.SEL_ERR};
            total++;
            if (obs !== e) $display("FAIL b2b[%0d] got %b want %b", i, obs, e);
            else passed++;
            if (obs[5:4] == 2'b00) both_on++;
            if (obs[5:4] == 2'b11) begin
                if (seen_en && !done) gap++;
            end else begin
                if (seen_en && gap > 0) done = 1'b1;
                seen_en = 1'b1;
            end
        end
        total++;
        if (gap != 3) $display("FAIL b2b_gap got %0d want 3", gap);
        else passed++;
        total++;
        if (both_on != 0) $display("FAIL b2b_overlap got %0d want 0", both_on);
        else passed++;
    endtask

    task automatic test_zero_dwell();
        logic [5:0] st [0:7] = '{6'b010110, 6'b010110, 6'b010110, 6'b000000,
                                 6'b011010, 6'b011010, 6'b000000, 6'b000000};
        logic [5:0] ex [0:7] = '{6'b100110, 6'b100110, 6'b100110, 6'b110100,
                                 6'b011110, 6'b011110, 6'b111100, 6'b111100};
        logic [5:0] obs, e;
        int gap = 0;
        logic seen_en = 1'b0, done = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            {bus_b.ACCESS, bus_b.SEL, bus_b.RW, bus_b.DMA} = st[i][4:0];
            sb.push_back(ex[i]);
            @(posedge clk); #1;
            e   = sb.pop_front();
            obs = {bus_b.BUFENn, bus_b.BUFDIR, bus_b.BUF_RDY, bus_b.SEL_ERR};
            total++;
            if (obs !== e) $display("FAIL zero_dwell[%0d] got %b want %b", i, obs, e);
            else passed++;
            if (obs[5:4] == 2'b11) begin
                if (seen_en && !done) gap++;
            end else begin
                if (seen_en && gap > 0) done = 1'b1;
                seen_en = 1'b1;
            end
        end
        total++;
        if (gap != 1) $display("FAIL zero_dwell_gap got %0d want 1", gap);
        else passed++;
    endtask

    task automatic test_sel_none_err();
        logic [5:0] st [0:6] = '{6'b010000, 6'b010000, 6'b011100, 6'b011100,
                                 6'b000000, 6'b010000, 6'b000000};
        logic [5:0] ex [0:6] = '{6'b111010, 6'b111010, 6'b111001, 6'b111001,
                                 6'b111000, 6'b111010, 6'b111000};
        logic [5:0] obs, e;
        for (int i = 0; i < 7; i++) begin
            {rst, bus_a.ACCESS, bus_a.SEL, bus_a.RW, bus_a.DMA} = st[i];
            sb.push_back(ex[i]);
            @(posedge clk); #1;
            e   = sb.pop_front();
            obs = {bus_a.BUFENn, bus_a.BUFDIR, bus_a.BUF_RDY, bus_a.SEL_ERR};
            total++;
            if (obs !== e) $display("FAIL sel_none_err[%0d] got %b want %b", i, obs, e);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] st [0:8] = '{6'b010110, 6'b010110, 6'b010110, 6'b110110, 6'b010110,
                                 6'b010110, 6'b000000, 6'b000000, 6'b000000};
        logic [5:0] ex [0:8] = '{6'b111100, 6'b101110, 6'b101110, 6'b110000, 6'b110100,
                                 6'b100110, 6'b110100, 6'b110100, 6'b110100};
        logic [5:0] obs, e;
        for (int i = 0; i < 9; i++) begin
            {rst, bus_a.ACCESS, bus_a.SEL, bus_a.RW, bus_a.DMA} = st[i];
            sb.push_back(ex[i]);
            @(posedge clk); #1;
            e   = sb.pop_front();
            obs = {bus_a.BUFENn, bus_a.BUFDIR, bus_a.BUF_RDY, bus_a.SEL_ERR};
            total++;
            if (obs !== e) $display("FAIL reset_mid[%0d] got %b want %b", i, obs, e);
            else passed++;
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus_a.ACCESS = 1'b0;
        bus_a.SEL    = '0;
        bus_a.RW     = 1'b0;
        bus_a.DMA    = 1'b0;
        bus_b.ACCESS = 1'b0;
        bus_b.SEL    = '0;
        bus_b.RW     = 1'b0;
        bus_b.DMA    = 1'b0;

        test_reset();
        test_read();
        test_dma();
        test_back_to_back();
        test_zero_dwell();
        test_sel_none_err();
        test_reset_mid();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
